// File: rtl/sdram_uart_burst_drain_pkg.sv
// ---------------------------------------------------------------------------
// sdram_uart_pkg
// Shared definitions for the SDRAM read-FIFO to UART burst drainer:
//   state_e        - FSM state encoding (IDLE, FETCH, DRAIN)
//   DATA_W_DEF     - default word width
//   BAUD_CNT_MAX_DEF - default clocks per UART bit minus 1
//   frame_cycles() - clock cycles in one UART frame period
// ---------------------------------------------------------------------------
package sdram_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int DATA_W_DEF       = 8;
  localparam int BAUD_CNT_MAX_DEF = 5207;

  function automatic int frame_cycles(input int baud_cnt_max, input int frame_bits);
    return frame_bits * (baud_cnt_max + 1);
  endfunction

endpackage

// File: rtl/sdram_uart_burst_drain_sync_fifo.sv
// ---------------------------------------------------------------------------
// sdram_uart_sync_fifo
// Single-clock FIFO holding one burst between the SDRAM fetch and the UART
// replay. q is registered: a read request loads q on the clock edge, so the
// word is visible in the following cycle.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset (flushes contents)
//   wr_en        - write strobe, wr_data stored on the edge
//   wr_data      - DATA_W write data
//   rd_req       - pop strobe
//   q            - DATA_W registered read data
//   usedw        - AW+1 bit fill level (DEPTH itself is representable)
// ---------------------------------------------------------------------------
module sdram_uart_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  output logic [DATA_W-1:0] q,
  output logic [AW:0]       usedw
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;

  // Storage array carries no reset; flushing is done through the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wr_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      usedw <= '0;
      q     <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_req) begin
        q    <= mem[rptr];
        rptr <= rptr + 1'b1;
      end
      case ({wr_en, rd_req})
        2'b10:   usedw <= usedw + 1'b1;
        2'b01:   usedw <= usedw - 1'b1;
        default: usedw <= usedw;
      endcase
    end
  end

  // The drainer never pops an empty buffer nor writes past DEPTH.
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(rd_req && usedw == '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_en && !rd_req && usedw == (AW+1)'(DEPTH)));

endmodule

// File: rtl/sdram_uart_burst_drain.sv
// ---------------------------------------------------------------------------
// sdram_uart_burst_drain
// Waits for the upstream SDRAM read FIFO to hold a full burst, fetches it
// into a local buffer, then replays one word per UART frame period as a
// tx_flag/tx_data strobe.
// Optional feature macro: SDRAM_UART_BURST_STATS_EN adds burst_cnt (wrapping
// count of completed bursts) and clamp_flag (sticky: burst_len > DEPTH seen).
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   rd_fifo_num     - upstream fill level (AW+1 bits)
//   rd_fifo_rd_data - upstream data, valid one cycle after rd_en
//   burst_len       - words per burst, clamped to DEPTH, sampled on start
//   rd_en           - upstream read request
//   tx_data/tx_flag - word and one-cycle strobe to the UART transmitter
//   busy            - high from burst start until return to idle
//   burst_done      - one-cycle pulse at the end of the last frame period
// ---------------------------------------------------------------------------
module sdram_uart_burst_drain
  import sdram_uart_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int DEPTH        = 1024,
  parameter int AW           = $clog2(DEPTH),
  parameter int BAUD_CNT_MAX = BAUD_CNT_MAX_DEF,
  parameter int FRAME_BITS   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW:0]       rd_fifo_num,
  input  logic [DATA_W-1:0] rd_fifo_rd_data,
  input  logic [AW:0]       burst_len,
  output logic              rd_en,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_flag,
  output logic              busy,
  output logic              burst_done
`ifdef SDRAM_UART_BURST_STATS_EN
  ,
  output logic [15:0]       burst_cnt,
  output logic              clamp_flag
`endif
);

  localparam int FRAME_CYC = frame_cycles(BAUD_CNT_MAX, FRAME_BITS);
  localparam int TW        = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(FRAME_CYC - 1);
  localparam logic [AW:0]   DEPTH_W    = (AW+1)'(DEPTH);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_FETCH = FETCH;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  logic [1:0]        state;
  logic [AW:0]       len_q;
  logic [AW:0]       rd_cnt;
  logic [AW:0]       wr_cnt;
  logic [AW:0]       sent_cnt;
  logic [TW-1:0]     timer;
  logic              wr_en_q;
  logic              pop_q;
  logic [DATA_W-1:0] fifo_q;
  logic [AW:0]       fifo_usedw;
  logic [AW:0]       blen_eff;
  logic              start_ok;
  logic              pop;

  assign blen_eff = (burst_len > DEPTH_W) ? DEPTH_W : burst_len;
  assign start_ok = (state == ST_IDLE) && (burst_len != '0) && (rd_fifo_num >= blen_eff);

  // A pop happens at the start of each frame period while words remain;
  // the usedw term is a belt-and-braces guard against popping empty.
  assign pop = (state == ST_DRAIN) && (timer == '0) && (sent_cnt < len_q)
               && (fifo_usedw != '0);

  assign burst_done = (state == ST_DRAIN) && (timer == TIMER_LAST) && (sent_cnt == len_q);

  // Main controller: wr_en_q/pop_q realign the upstream and buffer read
  // latencies so each stage sees valid data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      len_q    <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      sent_cnt <= '0;
      timer    <= '0;
      wr_en_q  <= 1'b0;
      pop_q    <= 1'b0;
      rd_en    <= 1'b0;
      busy     <= 1'b0;
      tx_flag  <= 1'b0;
      tx_data  <= '0;
    end else begin
      wr_en_q <= rd_en;
      pop_q   <= pop;
      tx_flag <= pop_q;
      if (pop_q) tx_data <= fifo_q;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state    <= ST_FETCH;
            len_q    <= blen_eff;
            rd_en    <= 1'b1;
            busy     <= 1'b1;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            sent_cnt <= '0;
            timer    <= '0;
          end
        end
        ST_FETCH: begin
          if (rd_en) begin
            rd_cnt <= rd_cnt + 1'b1;
            rd_en  <= (rd_cnt + 1'b1) < len_q;
          end
          if (wr_en_q) begin
            wr_cnt <= wr_cnt + 1'b1;
            if ((wr_cnt + 1'b1) == len_q) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          timer <= (timer == TIMER_LAST) ? '0 : timer + 1'b1;
          if (pop) sent_cnt <= sent_cnt + 1'b1;
          if (burst_done) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sdram_uart_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en_q),
    .wr_data (rd_fifo_rd_data),
    .rd_req  (pop),
    .q       (fifo_q),
    .usedw   (fifo_usedw)
  );

`ifdef SDRAM_UART_BURST_STATS_EN
  // Burst statistics: counter wraps freely, clamp_flag is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt  <= '0;
      clamp_flag <= 1'b0;
    end else begin
      if (burst_done) burst_cnt <= burst_cnt + 16'd1;
      if (start_ok && (burst_len > DEPTH_W)) clamp_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_uart_burst_drain.sv
// ---------------------------------------------------------------------------
// tb_sdram_uart_burst_drain
// Directed + randomized bench for sdram_uart_burst_drain with a small frame
// (BAUD_CNT_MAX=3, FRAME_BITS=10 -> 40 cycles) and DEPTH=16. An upstream FIFO
// model supplies words one cycle after rd_en; expected strobe data and
// timing come from burst arithmetic relative to the first rd_en cycle.
// ---------------------------------------------------------------------------
module tb_sdram_uart_burst_drain;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int BAUD   = 3;
  localparam int FBITS  = 10;
  localparam int FRAME  = FBITS * (BAUD + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [AW:0]       rd_fifo_num;
  logic [DATA_W-1:0] rd_fifo_rd_data;
  logic [AW:0]       burst_len;
  logic              rd_en;
  logic [DATA_W-1:0] tx_data;
  logic              tx_flag;
  logic              busy;
  logic              burst_done;
`ifdef SDRAM_UART_BURST_STATS_EN
  logic [15:0]       burst_cnt;
  logic              clamp_flag;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int bursts = 0;
  bit prev_rd_en = 1'b0;
  logic [DATA_W-1:0] src_q[$];

  always #5 clk = ~clk;

  sdram_uart_burst_drain #(
    .DATA_W       (DATA_W),
    .DEPTH        (DEPTH),
    .AW           (AW),
    .BAUD_CNT_MAX (BAUD),
    .FRAME_BITS   (FBITS)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rd_fifo_num     (rd_fifo_num),
    .rd_fifo_rd_data (rd_fifo_rd_data),
    .burst_len       (burst_len),
    .rd_en           (rd_en),
    .tx_data         (tx_data),
    .tx_flag         (tx_flag),
    .busy            (busy),
    .burst_done      (burst_done)
`ifdef SDRAM_UART_BURST_STATS_EN
    ,
    .burst_cnt       (burst_cnt),
    .clamp_flag      (clamp_flag)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample #1 after the edge; the upstream model presents the
  // next word in the cycle after it saw rd_en.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (prev_rd_en) rd_fifo_rd_data = (src_q.size() > 0) ? src_q.pop_front() : '0;
    prev_rd_en = rd_en;
  endtask

  task automatic idle_watch(input int n, input string tag);
    int rd_seen = 0;
    int busy_seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (rd_en) rd_seen++;
      if (busy) busy_seen++;
    end
    check({tag, "_rd_en"}, rd_seen, 0);
    check({tag, "_busy"}, busy_seen, 0);
  endtask

  // Runs one burst and checks it against the expected schedule:
  // rd_en for eff cycles from S, strobe k at S+eff+3+FRAME*k,
  // burst_done at S+eff+FRAME*eff, busy low the next cycle.
  task automatic run_burst(input int blen, input int num, input bit hold,
                           input int exp_start, input string tag);
    int eff, start, rd_cycles, last_rd, busy_start, strobes, done_cyc, bound;
    logic [DATA_W-1:0] exp_q[$];
    eff = (blen > DEPTH) ? DEPTH : blen;
    exp_q = {};
    for (int i = 0; i < eff; i++) exp_q.push_back(src_q[i]);
    start = -1; rd_cycles = 0; last_rd = -1; busy_start = -1;
    strobes = 0; done_cyc = -1;
    bound = 20 + eff * (FRAME + 1) + FRAME;
    burst_len = (AW+1)'(blen);
    rd_fifo_num = (AW+1)'(num);
    for (int c = 0; c < bound && done_cyc < 0; c++) begin
      tick();
      if (rd_en) begin
        if (start < 0) start = cyc;
        rd_cycles++;
        last_rd = cyc;
        if (!hold) rd_fifo_num = '0;
      end
      if (busy && busy_start < 0) busy_start = cyc;
      if (tx_flag) begin
        if (strobes < eff) begin
          check({tag, "_tx_data"}, tx_data, exp_q[strobes]);
          check({tag, "_tx_time"}, cyc, start + eff + 3 + FRAME * strobes);
        end
        strobes++;
      end
      if (burst_done) done_cyc = cyc;
    end
    check({tag, "_started"}, (start >= 0), 1);
    if (exp_start >= 0) check({tag, "_start_cyc"}, start, exp_start);
    check({tag, "_rd_cycles"}, rd_cycles, eff);
    check({tag, "_rd_contig"}, last_rd - start, eff - 1);
    check({tag, "_busy_rise"}, busy_start, start);
    check({tag, "_strobes"}, strobes, eff);
    check({tag, "_done_cyc"}, done_cyc, start + eff + FRAME * eff);
    tick();
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_done_after"}, burst_done, 0);
    bursts++;
  endtask

  task automatic load_random(input int n);
    src_q = {};
    for (int i = 0; i < n; i++) src_q.push_back(DATA_W'($urandom));
  endtask

  initial begin
    int seen, blen, num, eff;
    rst_n = 1'b0;
    rd_fifo_num = '0;
    rd_fifo_rd_data = '0;
    burst_len = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", rd_en, 0);
    check("rst_tx_flag", tx_flag, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_burst_done", burst_done, 0);
    rst_n = 1'b1;
    tick();

    // Directed burst of four words A1..A4
    src_q = {8'hA1, 8'hA2, 8'hA3, 8'hA4};
    run_burst(4, 4, 1'b0, -1, "t1");

    // Level above burst length starts a burst; below does not
    load_random(4);
    run_burst(4, 7, 1'b0, -1, "t2");
    burst_len = 5'd4;
    rd_fifo_num = 5'd3;
    idle_watch(200, "t2_below");

    // Zero burst length never starts
    burst_len = '0;
    rd_fifo_num = 5'd16;
    idle_watch(200, "t3_zero");
`ifdef SDRAM_UART_BURST_STATS_EN
    check("t3_clamp_clear", clamp_flag, 0);
`endif

    // Burst length above DEPTH is clamped
    load_random(20);
    run_burst(20, 20, 1'b0, -1, "t4");
`ifdef SDRAM_UART_BURST_STATS_EN
    check("t4_clamp_flag", clamp_flag, 1);
    check("t4_burst_cnt", burst_cnt, bursts);
`endif

    // Reset in DRAIN after the second strobe
    src_q = {8'hC0, 8'hC1, 8'hC2, 8'hC3};
    burst_len = 5'd4;
    rd_fifo_num = 5'd4;
    seen = 0;
    for (int i = 0; i < 400 && seen < 2; i++) begin
      tick();
      if (rd_en) rd_fifo_num = '0;
      if (tx_flag) seen++;
    end
    check("t5_two_strobes", seen, 2);
    rst_n = 1'b0;
    #1;
    check("t5_rst_rd_en", rd_en, 0);
    check("t5_rst_tx_flag", tx_flag, 0);
    check("t5_rst_tx_data", tx_data, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", burst_done, 0);
    prev_rd_en = 1'b0;
    bursts = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    rd_fifo_num = '0;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tx_flag) seen++;
    end
    check("t5_no_stale_flag", seen, 0);
`ifdef SDRAM_UART_BURST_STATS_EN
    check("t5_clamp_reset", clamp_flag, 0);
    check("t5_cnt_reset", burst_cnt, 0);
`endif
    src_q = {8'hB0, 8'hB1, 8'hB2, 8'hB3};
    run_burst(4, 4, 1'b0, -1, "t5_after");

    // Back-to-back bursts with the level held
    load_random(8);
    run_burst(4, 8, 1'b1, -1, "t6a");
    run_burst(4, 8, 1'b1, cyc + 1, "t6b");
    rd_fifo_num = '0;
`ifdef SDRAM_UART_BURST_STATS_EN
    check("t6_burst_cnt", burst_cnt, bursts);
`endif
    idle_watch(20, "t6_quiet");

    // Randomized bursts
    for (int r = 0; r < 3; r++) begin
      blen = $urandom_range(1, 20);
      eff = (blen > DEPTH) ? DEPTH : blen;
      num = $urandom_range(eff, 31);
      load_random(eff);
      run_burst(blen, num, 1'b0, -1, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
